// File: rtl/riscv_imem_loader_pkg.sv
// Shared types and constants for the RISC-V instruction-memory loader.
package riscv_imem_loader_pkg;

  localparam int unsigned LDR_BYTES_PER_WORD = 4;
  localparam int unsigned LDR_BYTE_W         = 8;
  localparam int unsigned LDR_WORD_W         = LDR_BYTES_PER_WORD * LDR_BYTE_W;
  localparam int unsigned LDR_LEN_W          = 16;
  localparam int unsigned LDR_BIDX_W         = $clog2(LDR_BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LDR_LEN_LO,
    LDR_LEN_HI,
    LDR_DATA,
    LDR_CSUM,
    LDR_DONE,
    LDR_ERROR
  } loader_state_e;

  // States in which the loader accepts stream bytes
  function automatic logic ldr_accepts_bytes(input loader_state_e s);
    return (s == LDR_LEN_LO) || (s == LDR_LEN_HI) ||
           (s == LDR_DATA)   || (s == LDR_CSUM);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream LSB-first into 32-bit words; pulses o_word_valid for one
// cycle after the fourth byte of each word.
module imem_word_packer
  import riscv_imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [LDR_BYTE_W-1:0] i_byte,
  output logic [LDR_BIDX_W-1:0] o_byte_idx,
  output logic                  o_word_valid,
  output logic [LDR_WORD_W-1:0] o_word
);

  logic [LDR_WORD_W-1:0] r_sr;
  logic [LDR_WORD_W-1:0] r_word;
  logic [LDR_BIDX_W-1:0] r_idx;
  logic                  r_word_valid;
  logic [LDR_WORD_W-1:0] w_sr_nxt;

  // New bytes enter at the top so the first byte ends up in bits [7:0]
  assign w_sr_nxt = {i_byte, r_sr[LDR_WORD_W-1:LDR_BYTE_W]};

  // Shift register, byte index and one-cycle word strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr         <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_sr         <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_sr  <= w_sr_nxt;
        r_idx <= r_idx + LDR_BIDX_W'(1);
        if (r_idx == LDR_BIDX_W'(LDR_BYTES_PER_WORD - 1)) begin
          r_word_valid <= 1'b1;
          r_word       <= w_sr_nxt;
        end
      end
    end
  end

  assign o_byte_idx   = r_idx;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/riscv_imem_loader.sv
// Receives a framed program byte stream, writes it into imem as 32-bit words
// and releases the core from reset once the frame checksum verifies.
module riscv_imem_loader
  import riscv_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned START_IDX = 0,
  parameter int unsigned MAX_WORDS = 64
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LDR_BYTE_W-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LDR_WORD_W-1:0] mem_wd,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  loader_state_e         r_state;
  loader_state_e         w_state_nxt;

  logic [LDR_LEN_W-1:0]  r_len;
  logic [LDR_LEN_W-1:0]  r_word_cnt;
  logic [LDR_BYTE_W-1:0] r_csum;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_rx_ready;
  logic                  r_core_rst;
  logic                  r_done;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_restart;
  logic                  w_data_xfer;
  logic                  w_word_last;
  logic [LDR_LEN_W-1:0]  w_len_nxt;
  logic [LDR_BIDX_W-1:0] w_byte_idx;
  logic                  w_word_valid;
  logic [LDR_WORD_W-1:0] w_word;

  assign w_xfer      = rx_valid & r_rx_ready;
  assign w_restart   = start & ((r_state == LDR_DONE) || (r_state == LDR_ERROR));
  assign w_data_xfer = w_xfer & (r_state == LDR_DATA);
  assign w_word_last = w_data_xfer &
                       (w_byte_idx == LDR_BIDX_W'(LDR_BYTES_PER_WORD - 1));
  assign w_len_nxt   = {rx_data, r_len[LDR_BYTE_W-1:0]};

  // Byte-to-word packing; cleared whenever a new frame is armed
  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_restart),
    .i_valid      (w_data_xfer),
    .i_byte       (rx_data),
    .o_byte_idx   (w_byte_idx),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LDR_LEN_LO;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: advances only on byte transfers or a re-arm pulse
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LDR_LEN_LO: begin
        if (w_xfer) w_state_nxt = LDR_LEN_HI;
      end
      LDR_LEN_HI: begin
        if (w_xfer) begin
          if (w_len_nxt == '0)
            w_state_nxt = LDR_CSUM;
          else if (w_len_nxt > LDR_LEN_W'(MAX_WORDS))
            w_state_nxt = LDR_ERROR;
          else
            w_state_nxt = LDR_DATA;
        end
      end
      LDR_DATA: begin
        if (w_word_last && (r_word_cnt == (r_len - LDR_LEN_W'(1))))
          w_state_nxt = LDR_CSUM;
      end
      LDR_CSUM: begin
        if (w_xfer) w_state_nxt = (rx_data == r_csum) ? LDR_DONE : LDR_ERROR;
      end
      LDR_DONE,
      LDR_ERROR: begin
        if (start) w_state_nxt = LDR_LEN_LO;
      end
      default: w_state_nxt = LDR_LEN_LO;
    endcase
  end

  // Frame length, word counter, checksum accumulator and write address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      r_mem_addr <= ADDR_W'(START_IDX);
    end else if (w_restart) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      r_mem_addr <= ADDR_W'(START_IDX);
    end else begin
      if (w_xfer && (r_state != LDR_CSUM))
        r_csum <= r_csum ^ rx_data;
      if (w_xfer && (r_state == LDR_LEN_LO))
        r_len <= {{(LDR_LEN_W-LDR_BYTE_W){1'b0}}, rx_data};
      if (w_xfer && (r_state == LDR_LEN_HI))
        r_len <= w_len_nxt;
      if (w_word_last) begin
        r_word_cnt <= r_word_cnt + LDR_LEN_W'(1);
        r_mem_addr <= ADDR_W'(START_IDX) + ADDR_W'(r_word_cnt);
      end
    end
  end

  // Status outputs registered from the next state so they track it exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_ready <= 1'b1;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_ready <= ldr_accepts_bytes(w_state_nxt);
      r_core_rst <= (w_state_nxt != LDR_DONE);
      r_done     <= (w_state_nxt == LDR_DONE);
      r_err      <= (w_state_nxt == LDR_ERROR);
    end
  end

  assign rx_ready = r_rx_ready;
  assign mem_we   = w_word_valid;
  assign mem_addr = r_mem_addr;
  assign mem_wd   = w_word;
  assign core_rst = r_core_rst;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader with a write scoreboard.
module tb_riscv_imem_loader;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned START_IDX = 0;
  localparam int unsigned MAX_WORDS = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              core_rst;
  logic              done;
  logic              err;

  int          total = 0;
  int          bad   = 0;
  int          ncyc  = 0;
  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] imem [256];
  logic [31:0] p1 [8];
  logic [31:0] p2 [8];

  always #5 clk = ~clk;

  riscv_imem_loader #(
    .ADDR_W    (ADDR_W),
    .START_IDX (START_IDX),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .start    (start),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every imem write must match the head of the scoreboard
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (rst === 1'b1 && mem_we !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", mem_wd, mon_e.data);
        check("wr_cycle", 32'(ncyc), mon_e.cyc);
        imem[mem_addr] = mem_wd;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at ncyc=%0d", ncyc);
    $fatal(1, "watchdog");
  end

  // Drive one byte; if it completes a word, schedule the write for the next cycle
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit wr,
                           input logic [31:0] wdata, input int widx);
    int waited;
    waited   = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL rx_ready_timeout observed=%b expected=1", rx_ready);
    end else if (wr) begin
      sb.push_back('{addr: ADDR_W'(START_IDX + widx), data: wdata, cyc: 32'(ncyc + 1)});
    end
    @(negedge clk); #1;
    rx_valid = 1'b0;
    if (gap) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [7:0] calc_csum(input logic [31:0] w [8], input int n);
    logic [7:0] c;
    c = 8'(n) ^ 8'(n >> 8);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 4; i++)
        c = c ^ 8'(w[k] >> (8 * i));
    return c;
  endfunction

  task automatic send_frame(input logic [31:0] w [8], input int n, input logic [7:0] csum,
                            input bit gap, input bit mid_start);
    send_byte(8'(n), gap, 1'b0, 32'd0, 0);
    send_byte(8'(n >> 8), gap, 1'b0, 32'd0, 0);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(8'(w[k] >> (8 * i)), gap, (i == 3), w[k], k);
        if (mid_start && k == 0 && i == 1) pulse_start();
      end
    end
    check("load_core_rst", 32'(core_rst), 32'd1);
    send_byte(csum, gap, 1'b0, 32'd0, 0);
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_core_rst, input logic e_rdy);
    check({tag, "_done"},     32'(done),     32'(e_done));
    check({tag, "_err"},      32'(err),      32'(e_err));
    check({tag, "_core_rst"}, 32'(core_rst), 32'(e_core_rst));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(e_rdy));
  endtask

  task automatic check_p1_imem(input string tag);
    check({tag, "_imem0"}, imem[START_IDX + 0], 32'h02024e63);
    check({tag, "_imem1"}, imem[START_IDX + 1], 32'h02004c63);
    check({tag, "_imem2"}, imem[START_IDX + 2], 32'h00404863);
  endtask

  initial begin
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    start    = 1'b0;
    p1 = '{32'h02024e63, 32'h02004c63, 32'h00404863, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    p2 = '{32'hdeadbeef, 32'h00000013, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    #1;

    // Reset values
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b1);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'(START_IDX));
    check("reset_mem_wd", mem_wd, 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Nominal three-word program
    send_frame(p1, 3, 8'h68, 1'b0, 1'b0);
    check_status("s1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("s1_sb_empty", 32'(sb.size()), 32'd0);
    check_p1_imem("s1");

    // Bad checksum: writes still happen, loader ends in ERROR
    pulse_start();
    check_status("s2_rearm", 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(p1, 3, 8'h69, 1'b0, 1'b0);
    check_status("s2", 1'b0, 1'b1, 1'b1, 1'b0);
    check("s2_sb_empty", 32'(sb.size()), 32'd0);

    // Oversized word count goes to ERROR straight after LEN_HI
    pulse_start();
    send_byte(8'(MAX_WORDS + 1), 1'b0, 1'b0, 32'd0, 0);
    send_byte(8'((MAX_WORDS + 1) >> 8), 1'b0, 1'b0, 32'd0, 0);
    check_status("s3_big", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;

    // Empty program with zero checksum
    pulse_start();
    send_frame(p1, 0, calc_csum(p1, 0), 1'b0, 1'b0);
    check_status("s3_empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // Same program with rx_valid gaps
    pulse_start();
    send_frame(p1, 3, calc_csum(p1, 3), 1'b1, 1'b0);
    check_status("s4", 1'b1, 1'b0, 1'b0, 1'b0);
    check("s4_sb_empty", 32'(sb.size()), 32'd0);
    check_p1_imem("s4");

    // Reset in the middle of word 1: only word 0 is written
    pulse_start();
    send_byte(8'd3, 1'b0, 1'b0, 32'd0, 0);
    send_byte(8'd0, 1'b0, 1'b0, 32'd0, 0);
    for (int i = 0; i < 4; i++)
      send_byte(8'(p1[0] >> (8 * i)), 1'b0, (i == 3), p1[0], 0);
    send_byte(8'(p1[1]), 1'b0, 1'b0, 32'd0, 0);
    send_byte(8'(p1[1] >> 8), 1'b0, 1'b0, 32'd0, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check_status("s5_rst", 1'b0, 1'b0, 1'b1, 1'b1);
    check("s5_rst_mem_we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    send_frame(p1, 3, 8'h68, 1'b0, 1'b0);
    check_status("s5", 1'b1, 1'b0, 1'b0, 1'b0);
    check_p1_imem("s5");

    // Re-arm from DONE, then a start pulse mid-DATA must be ignored
    pulse_start();
    check_status("s6_rearm", 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(p2, 2, calc_csum(p2, 2), 1'b0, 1'b1);
    check_status("s6", 1'b1, 1'b0, 1'b0, 1'b0);
    check("s6_imem0", imem[START_IDX + 0], 32'hdeadbeef);
    check("s6_imem1", imem[START_IDX + 1], 32'h00000013);
    check("s6_imem2", imem[START_IDX + 2], 32'h00404863);

    repeat (3) @(negedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
